// File: rtl/sd_audio_mc.sv
`default_nettype none
// ============================================================================
// Module   : sd_audio_mc
// Purpose  : Multi-channel sigma-delta audio player on the PicoRV32 native bus.
//            Firmware fills a circular buffer of interleaved channel samples.
//            A rate divider paces a fetch FSM that loads one frame per sample
//            period into per-channel hold registers. First-order sigma-delta
//            modulators turn the held samples into 1-bit PDM streams.
//            Half-buffer and wrap flags raise a level interrupt so firmware
//            can double-buffer.
// Ports    : clk        - system clock, rising edge
//            resetn     - asynchronous active-low reset
//            enable     - address-decoder select
//            mem_valid  - bus request
//            mem_ready  - bus acknowledge, one clock after acceptance
//            mem_wstrb  - byte write strobes (0 = read)
//            mem_wdata  - write data
//            mem_addr   - byte address; bit AW selects registers
//            mem_rdata  - read data, zero unless mem_ready
//            pdm_o      - PDM outputs, channel n on bit n
//            irq_o      - registered level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module sd_audio_mc #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 1024,
  parameter int DIV_W    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [3:0]          mem_wstrb,
  input  logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_addr,
  output logic [31:0]         mem_rdata,
  output logic [CHANNELS-1:0] pdm_o,
  output logic                irq_o
);

  localparam int c_PW   = $clog2(DEPTH);
  localparam int c_AW   = c_PW + 2;
  localparam int c_KW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_PERW = DIV_W + 1;
  localparam logic [c_PERW-1:0]   c_MIN_P     = c_PERW'(CHANNELS + 1);
  localparam logic [SAMPLE_W-1:0] c_SIGN_FLIP = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic            mem_ready_q;
  logic [31:0]     rdata_q;
  logic            accept;
  logic            is_write;
  logic            sel_reg;
  logic [c_PW-1:0] bus_idx;
  logic [1:0]      reg_idx;
  logic [31:0]     wmask;

  assign accept   = mem_valid & enable & ~mem_ready_q;
  assign is_write = |mem_wstrb;
  assign sel_reg  = mem_addr[c_AW];
  assign bus_idx  = mem_addr[c_AW-1:2];
  assign reg_idx  = mem_addr[3:2];
  assign wmask    = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                     {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

  // --------------------------------------------------------------------------
  // Sample buffer: one bus write/read port, one playback read port
  // --------------------------------------------------------------------------
  logic [31:0]     buf_mem [DEPTH];
  logic [c_PW-1:0] rd_ptr_q;
  logic [c_KW-1:0] k_q, k_d;
  logic [c_PW-1:0] fetch_idx;
  logic [31:0]     fetch_word;

  always_ff @(posedge clk) begin
    if (accept && !sel_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) buf_mem[bus_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign fetch_idx  = rd_ptr_q + c_PW'(k_q);
  assign fetch_word = buf_mem[fetch_idx];

  // --------------------------------------------------------------------------
  // Control / status registers
  // --------------------------------------------------------------------------
  logic [3:0]       ctrl_q;
  logic [DIV_W-1:0] div_reg_q;
  logic             half_q, wrap_q, irq_q;
  logic             run, signed_mode;
  logic             wr_ctrl, wr_div, wr_stat;
  logic             clr_half, clr_wrap, set_half, set_wrap;
  logic             advance;
  logic [c_PW-1:0]  rd_ptr_next;

  assign run         = ctrl_q[0];
  assign signed_mode = ctrl_q[3];
  assign wr_ctrl     = accept & is_write & sel_reg & (reg_idx == 2'd0);
  assign wr_div      = accept & is_write & sel_reg & (reg_idx == 2'd1);
  assign wr_stat     = accept & is_write & sel_reg & (reg_idx == 2'd2);
  assign clr_half    = wr_stat & mem_wstrb[2] & mem_wdata[16];
  assign clr_wrap    = wr_stat & mem_wstrb[2] & mem_wdata[17];
  assign rd_ptr_next = rd_ptr_q + c_PW'(CHANNELS);
  assign set_half    = advance & (rd_ptr_next == c_PW'(DEPTH / 2));
  assign set_wrap    = advance & (rd_ptr_next == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q    <= '0;
      div_reg_q <= '0;
      half_q    <= 1'b0;
      wrap_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= (ctrl_q & ~wmask[3:0]) | (mem_wdata[3:0] & wmask[3:0]);
      if (wr_div)  div_reg_q <= (div_reg_q & ~wmask[DIV_W-1:0]) |
                                (mem_wdata[DIV_W-1:0] & wmask[DIV_W-1:0]);
      // A set in the same cycle as a W1C clear wins
      half_q <= set_half | (half_q & ~clr_half);
      wrap_q <= set_wrap | (wrap_q & ~clr_wrap);
      irq_q  <= (half_q & ctrl_q[1]) | (wrap_q & ctrl_q[2]);
    end
  end

  // Read mux and bus response
  logic [31:0] rd_word;

  always_comb begin
    rd_word = 32'd0;
    if (sel_reg) begin
      case (reg_idx)
        2'd0: rd_word[3:0] = ctrl_q;
        2'd1: rd_word[DIV_W-1:0] = div_reg_q;
        2'd2: begin
          rd_word[c_PW-1:0] = rd_ptr_q;
          rd_word[16]       = half_q;
          rd_word[17]       = wrap_q;
        end
        default: rd_word = 32'd0;
      endcase
    end else begin
      rd_word = buf_mem[bus_idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mem_ready_q <= accept;
      rdata_q     <= (accept && !is_write) ? rd_word : 32'd0;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = rdata_q;
  assign irq_o     = irq_q;

  // --------------------------------------------------------------------------
  // Rate divider. The period is relatched only while stopped or at the
  // terminal count, so a DIV write lands at the next wrap.
  // --------------------------------------------------------------------------
  logic [c_PERW-1:0] div_cnt_q, period_q, period_new, div_plus1;
  logic              tc;

  assign div_plus1  = {1'b0, div_reg_q} + c_PERW'(1);
  assign period_new = (div_plus1 > c_MIN_P) ? div_plus1 : c_MIN_P;
  assign tc         = run & (div_cnt_q == (period_q - c_PERW'(1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q <= '0;
      period_q  <= c_MIN_P;
    end else if (!run || tc) begin
      div_cnt_q <= '0;
      period_q  <= period_new;
    end else begin
      div_cnt_q <= div_cnt_q + c_PERW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM
  // --------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   fetch_last;

  assign fetch_last = (k_q == c_KW'(CHANNELS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    advance = 1'b0;
    if (!run) begin
      state_d = S_IDLE;
      k_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
          k_d     = '0;
        end
        S_FETCH: begin
          k_d = k_q + c_KW'(1);
          if (fetch_last) begin
            k_d = '0;
            // With the minimum period the very first terminal count lands on
            // the last fetch cycle (the IDLE cycle already consumed a count);
            // the word being fetched is forwarded straight into hold.
            if (tc) begin
              advance = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (tc) begin
            advance = 1'b1;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Staging / hold registers and read pointer
  logic [SAMPLE_W-1:0] stage_q [CHANNELS];
  logic [SAMPLE_W-1:0] hold_q  [CHANNELS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        stage_q[n] <= '0;
        hold_q[n]  <= '0;
      end
    end else if (!run) begin
      rd_ptr_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        stage_q[n] <= '0;
        hold_q[n]  <= '0;
      end
    end else begin
      if (state_q == S_FETCH) begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (k_q == c_KW'(n)) stage_q[n] <= fetch_word[SAMPLE_W-1:0];
        end
      end
      if (advance) begin
        for (int n = 0; n < CHANNELS; n++) hold_q[n] <= stage_q[n];
        if (state_q == S_FETCH) hold_q[CHANNELS-1] <= fetch_word[SAMPLE_W-1:0];
        rd_ptr_q <= rd_ptr_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // First-order sigma-delta modulators, one per channel. The sample is
  // converted to offset binary; the carry out of the accumulator is the PDM bit.
  // --------------------------------------------------------------------------
  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    logic [SAMPLE_W-1:0] u;
    logic [SAMPLE_W:0]   sum;
    logic [SAMPLE_W-1:0] acc_q;
    logic                bit_q;

    assign u   = hold_q[n] ^ (signed_mode ? c_SIGN_FLIP : '0);
    assign sum = {1'b0, acc_q} + {1'b0, u};

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        acc_q <= '0;
        bit_q <= 1'b0;
      end else if (!run) begin
        acc_q <= '0;
        bit_q <= 1'b0;
      end else begin
        acc_q <= sum[SAMPLE_W-1:0];
        bit_q <= sum[SAMPLE_W];
      end
    end

    assign pdm_o[n] = bit_q;
  end

  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:c_AW+1], mem_addr[1:0], fetch_word[31:SAMPLE_W]};

endmodule
`default_nettype wire

// File: tb/tb_sd_audio_mc.sv
`default_nettype none
module tb_sd_audio_mc;

  localparam int CH    = 2;
  localparam int SW    = 16;
  localparam int DEPTH = 16;
  localparam int DIVW  = 16;

  localparam logic [31:0] A_CTRL = 32'h40;
  localparam logic [31:0] A_DIV  = 32'h44;
  localparam logic [31:0] A_STAT = 32'h48;
  localparam logic [31:0] A_R3   = 32'h4C;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          mem_valid = 1'b0;
  logic [3:0]    mem_wstrb = 4'd0;
  logic [31:0]   mem_wdata = 32'd0;
  logic [31:0]   mem_addr = 32'd0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [CH-1:0] pdm_o;
  logic          irq_o;

  sd_audio_mc #(.CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEPTH), .DIV_W(DIVW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .pdm_o(pdm_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- bus
  int          acc_edge;
  logic [31:0] rd_val;

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1;
    mem_addr = addr; mem_wstrb = strb; mem_wdata = data;
    @(posedge clk); #1;
    acc_edge = cyc;
    mem_valid = 1'b0; enable = 1'b0;
    rd_val = mem_rdata;
    check("ready_after_1clk", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    check("ready_one_clk_only", 32'(mem_ready), 32'd0);
    check("rdata_zero_idle", mem_rdata, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(addr, 4'hF, data);
  endtask

  task automatic rd(input logic [31:0] addr);
    bus(addr, 4'h0, 32'd0);
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  // ---------------------------------------------------------------- model
  logic [31:0] shadow [DEPTH];
  int          per;
  bit          sgn;
  int          run_edge;

  task automatic fill_random();
    for (int w = 0; w < DEPTH; w++) begin
      shadow[w] = $urandom;
      wr(32'(w * 4), shadow[w]);
    end
  endtask

  task automatic fill_pair(input logic [31:0] a, input logic [31:0] b);
    for (int w = 0; w < DEPTH; w++) begin
      shadow[w] = (w % CH == 0) ? a : b;
      wr(32'(w * 4), shadow[w]);
    end
  endtask

  // Playback reference: frame f (words f*CH..) becomes audible in the hold
  // registers at edge (f+1)*per after the run-enabling edge; each modulator
  // adds the offset-binary sample to a SW-bit accumulator, emitting the carry.
  task automatic play_check(input int ncyc);
    int            macc [CH];
    int            m, idx, smp, u;
    logic [CH-1:0] exp_pdm;
    for (int n = 0; n < CH; n++) macc[n] = 0;
    for (int j = 1; j <= ncyc; j++) begin
      if (j > cyc - run_edge) begin @(posedge clk); #1; end
      m = j - 1;
      for (int n = 0; n < CH; n++) begin
        if (m < per) smp = 0;
        else begin
          idx = ((m / per - 1) * CH + n) % DEPTH;
          smp = int'(shadow[idx][SW-1:0]);
        end
        u = sgn ? (smp ^ (1 << (SW - 1))) : smp;
        macc[n] = (macc[n] % (1 << SW)) + u;
        exp_pdm[n] = (macc[n] >= (1 << SW));
      end
      check($sformatf("pdm_cycle_%0d", j), 32'(pdm_o), 32'(exp_pdm));
    end
  endtask

  function automatic logic [31:0] flags_after(input int advances);
    logic h, w;
    int   p;
    h = 1'b0; w = 1'b0;
    for (int k = 1; k <= advances; k++) begin
      p = (k * CH) % DEPTH;
      if (p == DEPTH / 2) h = 1'b1;
      if (p == 0) w = 1'b1;
    end
    return {14'd0, w, h, 16'd0};
  endfunction

  task automatic count_ones(input int ncyc, output int o0, output int o1);
    o0 = 0; o1 = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      o0 += int'(pdm_o[0]);
      o1 += int'(pdm_o[1]);
    end
  endtask

  task automatic wait_irq_rise(input int limit, output int edge_idx);
    edge_idx = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (irq_o) begin edge_idx = cyc; break; end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dv, n, stop_edge, rise, ones0, ones1;
    logic [31:0] st;

    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pdm", 32'(pdm_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    @(negedge clk); resetn = 1'b1;

    rd(A_CTRL);  check("rst_ctrl", rd_val, 32'd0);
    rd(A_DIV);   check("rst_div", rd_val, 32'd0);
    rd(A_STAT);  check("rst_status", rd_val, 32'd0);

    // ---------------- bus byte strobes
    wr(32'h0C, 32'h11223344);
    bus(32'h0C, 4'b0010, 32'hA5A5A5A5);
    rd(32'h0C);  check("byte1_strobe", rd_val, 32'h1122A544);
    wr(A_R3, 32'hFFFFFFFF);
    rd(A_R3);    check("reg3_reads_zero", rd_val, 32'd0);
    wr(A_DIV, 32'h0000BEEF);
    rd(A_DIV);   check("div_rw", rd_val, 32'h0000BEEF);

    // ---------------- randomized playback against the reference model
    for (int it = 0; it < 4; it++) begin
      wr(A_STAT, 32'h00030000);
      fill_random();
      dv  = (it == 0) ? 0 : (it == 1) ? 2 : int'($urandom_range(3, 9));
      per = (dv + 1 > CH + 1) ? dv + 1 : CH + 1;
      sgn = 1'($urandom_range(0, 1));
      wr(A_DIV, 32'(dv));
      wr(A_CTRL, sgn ? 32'h9 : 32'h1);
      run_edge = acc_edge;
      n = 20 * per + int'($urandom_range(0, 7));
      play_check(n);
      wr(A_CTRL, 32'h0);
      stop_edge = acc_edge;
      check("stop_pdm_zero", 32'(pdm_o), 32'd0);
      check("irq_masked", 32'(irq_o), 32'd0);
      rd(A_STAT);
      check("flags_after_run", rd_val, flags_after((stop_edge - run_edge) / per));
    end

    // ---------------- DC levels, unsigned
    fill_pair(32'h00004000, 32'h0000C000);
    wr(A_DIV, 32'd7);
    wr(A_CTRL, 32'h1);
    repeat (20) @(posedge clk);
    count_ones(32768, ones0, ones1);
    check($sformatf("dc_ch0_ones_%0d", ones0), 32'(ones0 >= 8191 && ones0 <= 8193), 32'd1);
    check($sformatf("dc_ch1_ones_%0d", ones1), 32'(ones1 >= 24575 && ones1 <= 24577), 32'd1);
    wr(A_CTRL, 32'h0);

    // ---------------- signed mode extremes
    fill_pair(32'h00000000, 32'h00008000);
    wr(A_CTRL, 32'h9);
    repeat (20) @(posedge clk);
    count_ones(4096, ones0, ones1);
    check($sformatf("signed_zero_ones_%0d", ones0), 32'(ones0 >= 2047 && ones0 <= 2049), 32'd1);
    check("signed_min_ones", 32'(ones1), 32'd0);
    wr(A_CTRL, 32'h0);

    // ---------------- interrupts, W1C, set-wins, stop mid-frame
    fill_random();
    wr(A_STAT, 32'h00030000);
    wr(A_DIV, 32'd3);
    per = 4;
    wr(A_CTRL, 32'h7);
    run_edge = acc_edge;
    wait_irq_rise(200, rise);
    check("irq_half_edge", 32'(rise - run_edge), 32'(4 * per + 1));
    rd(A_STAT);
    check("status_half", rd_val,
          32'h00010000 | 32'((CH * ((acc_edge - 1 - run_edge) / per)) % DEPTH));
    wr(A_STAT, 32'h00010000);
    check("irq_dropped_w1c", 32'(irq_o), 32'd0);
    wait_irq_rise(200, rise);
    check("irq_wrap_edge", 32'(rise - run_edge), 32'(8 * per + 1));
    wr(A_STAT, 32'h00020000);
    check("irq_dropped_wrap", 32'(irq_o), 32'd0);
    // W1C lands on the same edge as the third half-buffer advance
    wait_edge(run_edge + 12 * per - 1);
    wr(A_STAT, 32'h00010000);
    check("w1c_same_cycle_irq", 32'(irq_o), 32'd1);
    rd(A_STAT);
    check("w1c_same_cycle_flag", rd_val,
          32'h00010000 | 32'((CH * ((acc_edge - 1 - run_edge) / per)) % DEPTH));
    // Stop one edge after a frame load, i.e. mid-fetch
    wait_edge(run_edge + 13 * per);
    wr(A_CTRL, 32'h6);
    check("stop_fetch_pdm", 32'(pdm_o), 32'd0);
    check("stop_fetch_irq_kept", 32'(irq_o), 32'd1);
    rd(A_STAT);
    check("stop_fetch_status", rd_val, 32'h00010000);

    // ---------------- replay from word 0
    fill_random();
    sgn = 1'b0;
    wr(A_CTRL, 32'h1);
    run_edge = acc_edge;
    play_check(12 * per);

    // ---------------- asynchronous reset mid-playback
    wr(A_CTRL, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_irq", 32'(irq_o), 32'd1);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    check("async_rst_pdm", 32'(pdm_o), 32'd0);
    check("async_rst_irq", 32'(irq_o), 32'd0);
    check("async_rst_ready", 32'(mem_ready), 32'd0);
    check("async_rst_rdata", mem_rdata, 32'd0);
    @(negedge clk); resetn = 1'b1;
    rd(A_CTRL);  check("post_rst_ctrl", rd_val, 32'd0);
    rd(A_STAT);  st = rd_val;
    check("post_rst_status", st, 32'd0);
    check("post_rst_pdm", 32'(pdm_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
